mem_bus_arbiter: RTL and testbench

//  Shares one external memory bus port between two requesters: instruction fetch (I) and the MEM stage (D).
//  MEM stage drives the D side with ce/we/addr/data/sel.

---
 rtl/mem_bus_arbiter_pkg.sv | 16 +
 rtl/mem_bus_arbiter_timeout_cnt.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encodings,
// state bus width and the all-lanes byte-enable constant.
package mem_bus_arbiter_pkg;

    localparam int ArbStateBus = 2;

    typedef enum logic [ArbStateBus-1:0] {
        ArbIdle = 2'd0,
        ArbDbus = 2'd1,
        ArbIbus = 2'd2
    } arb_state_t;

    // Wide enough for any sensible data width; the top slices it down to its sel width.
    localparam logic [63:0] SelAllOnesMax = '1;

endpackage

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// Bus-wait watchdog for the memory bus arbiter.
// Only instantiated when ARB_TIMEOUT_EN is defined.
// The count restarts on every grant and saturates at TIMEOUT, where expired_o goes high.
module arb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    assign expired_o = (cnt_q == CntW'(TIMEOUT));

    // Next count: restart on grant, otherwise count waiting cycles up to the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch (I) and the MEM stage (D).
// D normally wins, but I is granted right after a D grant when both are pending.
// Optional bus-wait timeout enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_ce_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_ack_o,
    input  logic                mem_ce_i,
    input  logic                mem_we_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_data_i,
    input  logic [DATA_W/8-1:0] mem_sel_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_ack_o,
    output logic                bus_cyc_o,
    output logic                bus_we_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    input  logic                bus_ack_i,
    output logic                stallreq_if_o,
`ifdef ARB_TIMEOUT_EN
    output logic                stallreq_mem_o,
    output logic                timeout_err_o
`else
    output logic                stallreq_mem_o
`endif
);

    localparam int SelW = DATA_W / 8;
    localparam logic [SelW-1:0] SelAllOnes = SelAllOnesMax[SelW-1:0];

    arb_state_t        state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              bus_cyc_q, bus_cyc_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [SelW-1:0]   bus_sel_q, bus_sel_d;
    logic              if_ack_q, if_ack_d;
    logic              mem_ack_q, mem_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_req, mem_req;
    logic              expired;

    // A request still high in its own ack cycle is the old one; it only counts from the next cycle.
    assign if_req  = if_ce_i & ~if_ack_q;
    assign mem_req = mem_ce_i & ~mem_ack_q;

    assign stallreq_if_o  = if_ce_i & ~if_ack_q;
    assign stallreq_mem_o = mem_ce_i & ~mem_ack_q;

    assign bus_cyc_o   = bus_cyc_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_sel_o   = bus_sel_q;
    assign if_ack_o    = if_ack_q;
    assign mem_ack_o   = mem_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign mem_rdata_o = mem_rdata_q;

`ifdef ARB_TIMEOUT_EN
    logic grant;
    logic timeout_hit;
    logic timeout_err_q, timeout_err_d;

    assign grant       = (state_q == ArbIdle) && (state_d != ArbIdle);
    assign timeout_hit = (state_q != ArbIdle) && !bus_ack_i && expired;

    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (grant),
        .enable_i  ((state_q != ArbIdle) && !bus_ack_i),
        .expired_o (expired)
    );

    assign timeout_err_d = timeout_err_q | timeout_hit;
    assign timeout_err_o = timeout_err_q;

    // Sticky timeout flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_d;
        end
    end
`else
    // Without the watchdog a bus access waits forever; TIMEOUT has no effect here.
    assign expired = (TIMEOUT < 0);
`endif

    // Arbitration, grant latching and completion handling.
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        bus_cyc_d   = bus_cyc_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            ArbIdle: begin
                if (mem_req && !(last_d_q && if_req)) begin
                    state_d     = ArbDbus;
                    last_d_d    = 1'b1;
                    bus_cyc_d   = 1'b1;
                    bus_we_d    = mem_we_i;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_data_i;
                    bus_sel_d   = mem_sel_i;
                end else if (if_req) begin
                    state_d     = ArbIbus;
                    last_d_d    = 1'b0;
                    bus_cyc_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr_i;
                    bus_wdata_d = '0;
                    bus_sel_d   = SelAllOnes;
                end
            end
            ArbDbus: begin
                if (bus_ack_i || expired) begin
                    state_d     = ArbIdle;
                    bus_cyc_d   = 1'b0;
                    mem_ack_d   = 1'b1;
                    mem_rdata_d = (bus_ack_i && !bus_we_q) ? bus_rdata_i : '0;
                end
            end
            ArbIbus: begin
                if (bus_ack_i || expired) begin
                    state_d    = ArbIdle;
                    bus_cyc_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = bus_ack_i ? bus_rdata_i : '0;
                end
            end
            default: begin
                state_d   = ArbIdle;
                bus_cyc_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight access without an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ArbIdle;
            last_d_q    <= 1'b0;
            bus_cyc_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            bus_cyc_q   <= bus_cyc_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios plus a randomized run
// against a transaction-level model. Define ARB_TIMEOUT_EN to also cover the watchdog.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = DATA_W / 8;
`ifdef ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              if_ce_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ack_o;
    logic              mem_ce_i;
    logic              mem_we_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_data_i;
    logic [SEL_W-1:0]  mem_sel_i;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              mem_ack_o;
    logic              bus_cyc_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic [SEL_W-1:0]  bus_sel_o;
    logic [DATA_W-1:0] bus_rdata_i;
    logic              bus_ack_i;
    logic              stallreq_if_o;
    logic              stallreq_mem_o;
`ifdef ARB_TIMEOUT_EN
    logic              timeout_err_o;
`endif

    int nCompared   = 0;
    int nMismatched = 0;

    mem_bus_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_ce_i        (if_ce_i),
        .if_addr_i      (if_addr_i),
        .if_rdata_o     (if_rdata_o),
        .if_ack_o       (if_ack_o),
        .mem_ce_i       (mem_ce_i),
        .mem_we_i       (mem_we_i),
        .mem_addr_i     (mem_addr_i),
        .mem_data_i     (mem_data_i),
        .mem_sel_i      (mem_sel_i),
        .mem_rdata_o    (mem_rdata_o),
        .mem_ack_o      (mem_ack_o),
        .bus_cyc_o      (bus_cyc_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o     (bus_addr_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_sel_o      (bus_sel_o),
        .bus_rdata_i    (bus_rdata_i),
        .bus_ack_i      (bus_ack_i),
        .stallreq_if_o  (stallreq_if_o),
`ifdef ARB_TIMEOUT_EN
        .stallreq_mem_o (stallreq_mem_o),
        .timeout_err_o  (timeout_err_o)
`else
        .stallreq_mem_o (stallreq_mem_o)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Move to 1 time unit after the next rising edge; registered outputs are stable there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        if_ce_i = 1'b0; if_addr_i = '0;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_data_i = '0; mem_sel_i = '0;
        bus_ack_i = 1'b0; bus_rdata_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    // Everything registered is zero under reset; stall requests still follow ce.
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        mem_ce_i = 1'b1; if_ce_i = 1'b1;
        step(); step(); settle();
        nCompared++;
        if ({bus_cyc_o, bus_we_o, mem_ack_o, if_ack_o} !== 4'b0) begin
            nMismatched++; $display("[TB] FAIL reset_ctrl: got %b expected 0000", {bus_cyc_o, bus_we_o, mem_ack_o, if_ack_o});
        end
        nCompared++;
        if ({bus_addr_o, bus_wdata_o, bus_sel_o} !== '0) begin
            nMismatched++; $display("[TB] FAIL reset_bus: got %h/%h/%h expected 0", bus_addr_o, bus_wdata_o, bus_sel_o);
        end
        nCompared++;
        if ({mem_rdata_o, if_rdata_o} !== '0) begin
            nMismatched++; $display("[TB] FAIL reset_rdata: got %h/%h expected 0", mem_rdata_o, if_rdata_o);
        end
        nCompared++;
        if ({stallreq_mem_o, stallreq_if_o} !== 2'b11) begin
            nMismatched++; $display("[TB] FAIL reset_stall: got %b expected 11", {stallreq_mem_o, stallreq_if_o});
        end
        mem_ce_i = 1'b0; if_ce_i = 1'b0;
        rst = 1'b0;
        step(); settle();
        nCompared++;
        if ({bus_cyc_o, stallreq_mem_o, stallreq_if_o} !== 3'b000) begin
            nMismatched++; $display("[TB] FAIL reset_idle: got %b expected 000", {bus_cyc_o, stallreq_mem_o, stallreq_if_o});
        end
    endtask

    // Single D read, bus answers three cycles after the cycle starts.
    task automatic test_d_read();
        do_reset();
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0100; mem_sel_i = 4'hF;
        step();
        nCompared++;
        if ({bus_cyc_o, bus_we_o, bus_addr_o} !== {2'b10, 32'h0000_0100}) begin
            nMismatched++; $display("[TB] FAIL d_read_grant: got cyc=%b we=%b addr=%h expected cyc=1 we=0 addr=00000100", bus_cyc_o, bus_we_o, bus_addr_o);
        end
        for (int i = 0; i < 2; i++) begin
            step(); settle();
            nCompared++;
            if ({bus_cyc_o, stallreq_mem_o, mem_ack_o} !== 3'b110) begin
                nMismatched++; $display("[TB] FAIL d_read_wait: got %b expected 110", {bus_cyc_o, stallreq_mem_o, mem_ack_o});
            end
        end
        step();
        bus_ack_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
        step();
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        settle();
        nCompared++;
        if ({mem_ack_o, if_ack_o, bus_cyc_o, stallreq_mem_o} !== 4'b1000) begin
            nMismatched++; $display("[TB] FAIL d_read_ack: got ack/iack/cyc/stall=%b expected 1000", {mem_ack_o, if_ack_o, bus_cyc_o, stallreq_mem_o});
        end
        nCompared++;
        if (mem_rdata_o !== 32'hDEAD_BEEF) begin
            nMismatched++; $display("[TB] FAIL d_read_data: got %h expected deadbeef", mem_rdata_o);
        end
        mem_ce_i = 1'b0;
        step();
        nCompared++;
        if ({mem_ack_o, bus_cyc_o, mem_rdata_o} !== {2'b00, 32'hDEAD_BEEF}) begin
            nMismatched++; $display("[TB] FAIL d_read_hold: got ack=%b cyc=%b rdata=%h expected 0 0 deadbeef", mem_ack_o, bus_cyc_o, mem_rdata_o);
        end
    endtask

    // Both sides request together after reset: D first, then I with we=0 and all byte lanes.
    task automatic test_simultaneous();
        do_reset();
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h300; mem_data_i = 32'h5555; mem_sel_i = 4'b0101;
        if_ce_i = 1'b1; if_addr_i = 32'h2000;
        step();
        nCompared++;
        if ({bus_cyc_o, bus_we_o, bus_addr_o, bus_sel_o} !== {2'b11, 32'h300, 4'b0101}) begin
            nMismatched++; $display("[TB] FAIL simul_d_first: got cyc=%b we=%b addr=%h sel=%b expected 1 1 00000300 0101", bus_cyc_o, bus_we_o, bus_addr_o, bus_sel_o);
        end
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_1111;
        step();
        bus_ack_i = 1'b0;
        nCompared++;
        if ({mem_ack_o, if_ack_o, mem_rdata_o} !== {2'b10, 32'h0}) begin
            nMismatched++; $display("[TB] FAIL simul_d_ack: got mack=%b iack=%b rdata=%h expected 1 0 00000000", mem_ack_o, if_ack_o, mem_rdata_o);
        end
        mem_ce_i = 1'b0;
        settle();
        nCompared++;
        if (stallreq_if_o !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL simul_i_stall: got %b expected 1", stallreq_if_o);
        end
        step();
        nCompared++;
        if ({bus_cyc_o, bus_we_o, bus_addr_o, bus_sel_o} !== {2'b10, 32'h2000, 4'b1111}) begin
            nMismatched++; $display("[TB] FAIL simul_i_grant: got cyc=%b we=%b addr=%h sel=%b expected 1 0 00002000 1111", bus_cyc_o, bus_we_o, bus_addr_o, bus_sel_o);
        end
        bus_ack_i = 1'b1; bus_rdata_i = 32'h2222_2222;
        step();
        bus_ack_i = 1'b0;
        nCompared++;
        if ({if_ack_o, mem_ack_o, if_rdata_o} !== {2'b10, 32'h2222_2222}) begin
            nMismatched++; $display("[TB] FAIL simul_i_ack: got iack=%b mack=%b rdata=%h expected 1 0 22222222", if_ack_o, mem_ack_o, if_rdata_o);
        end
        if_ce_i = 1'b0;
        step();
    endtask

    // D write: bus fields are latched at grant and held even if the inputs move.
    task automatic test_write();
        do_reset();
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h40; mem_data_i = 32'h0000_ABCD; mem_sel_i = 4'b0011;
        step();
        for (int i = 0; i < 3; i++) begin
            nCompared++;
            if ({bus_cyc_o, bus_we_o, bus_sel_o, bus_wdata_o, bus_addr_o} !== {2'b11, 4'b0011, 32'h0000_ABCD, 32'h40}) begin
                nMismatched++; $display("[TB] FAIL write_hold: got cyc=%b we=%b sel=%b wdata=%h addr=%h expected 1 1 0011 0000abcd 00000040", bus_cyc_o, bus_we_o, bus_sel_o, bus_wdata_o, bus_addr_o);
            end
            mem_data_i = $urandom; mem_sel_i = 4'($urandom); mem_addr_i = $urandom;
            step();
        end
        bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
        step();
        bus_ack_i = 1'b0;
        nCompared++;
        if ({mem_ack_o, bus_cyc_o, mem_rdata_o} !== {2'b10, 32'h0}) begin
            nMismatched++; $display("[TB] FAIL write_ack: got ack=%b cyc=%b rdata=%h expected 1 0 00000000", mem_ack_o, bus_cyc_o, mem_rdata_o);
        end
        mem_ce_i = 1'b0;
        step();
    endtask

    // D keeps requesting while I waits: grants must go D, I, D.
    task automatic test_back_to_back();
        logic [ADDR_W-1:0] grants[$];
        logic [ADDR_W-1:0] expOrder[3];
        logic prevCyc = 1'b0;
        int   dDone = 0;
        expOrder[0] = 32'h10; expOrder[1] = 32'h20; expOrder[2] = 32'h14;
        do_reset();
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h10; mem_sel_i = 4'hF;
        if_ce_i = 1'b1; if_addr_i = 32'h20;
        for (int c = 0; c < 30 && grants.size() < 3; c++) begin
            step();
            if (bus_cyc_o === 1'b1 && !prevCyc) grants.push_back(bus_addr_o);
            prevCyc = bus_cyc_o;
            if (mem_ack_o === 1'b1) begin
                dDone++;
                if (dDone == 1) mem_addr_i = 32'h14;
                else mem_ce_i = 1'b0;
            end
            if (if_ack_o === 1'b1) if_ce_i = 1'b0;
            bus_ack_i = bus_cyc_o;
        end
        bus_ack_i = 1'b0;
        nCompared++;
        if (grants.size() !== 3) begin
            nMismatched++; $display("[TB] FAIL b2b_count: got %0d grants expected 3", grants.size());
        end
        for (int i = 0; i < 3 && i < grants.size(); i++) begin
            nCompared++;
            if (grants[i] !== expOrder[i]) begin
                nMismatched++; $display("[TB] FAIL b2b_order[%0d]: got %h expected %h", i, grants[i], expOrder[i]);
            end
        end
        clear_inputs();
        step(); step();
    endtask

    // Reset during an open cycle drops it with no ack; the arbiter is idle afterwards.
    task automatic test_reset_mid();
        do_reset();
        mem_ce_i = 1'b1; mem_addr_i = 32'h80; mem_sel_i = 4'hF;
        step();
        nCompared++;
        if (bus_cyc_o !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL rstmid_grant: got cyc=%b expected 1", bus_cyc_o);
        end
        step();
        rst = 1'b1;
        step();
        nCompared++;
        if ({bus_cyc_o, mem_ack_o} !== 2'b00) begin
            nMismatched++; $display("[TB] FAIL rstmid_drop: got cyc/ack=%b expected 00", {bus_cyc_o, mem_ack_o});
        end
        rst = 1'b0; mem_ce_i = 1'b0;
        step();
        nCompared++;
        if ({bus_cyc_o, mem_ack_o} !== 2'b00) begin
            nMismatched++; $display("[TB] FAIL rstmid_noack: got cyc/ack=%b expected 00", {bus_cyc_o, mem_ack_o});
        end
        if_ce_i = 1'b1; if_addr_i = 32'h90;
        step();
        nCompared++;
        if ({bus_cyc_o, bus_addr_o} !== {1'b1, 32'h90}) begin
            nMismatched++; $display("[TB] FAIL rstmid_idle: got cyc=%b addr=%h expected 1 00000090", bus_cyc_o, bus_addr_o);
        end
        bus_ack_i = 1'b1; bus_rdata_i = 32'h9;
        step();
        bus_ack_i = 1'b0; if_ce_i = 1'b0;
        step();
    endtask

`ifdef ARB_TIMEOUT_EN
    // Bus never answers: after TIMEOUT waiting cycles D gets an ack with zero data and the flag sticks.
    task automatic test_timeout();
        int ackAt = -1;
        do_reset();
        mem_ce_i = 1'b1; mem_addr_i = 32'h500; mem_sel_i = 4'hF;
        for (int c = 1; c <= 8 && ackAt < 0; c++) begin
            step();
            if (mem_ack_o === 1'b1) begin
                ackAt = c;
                mem_ce_i = 1'b0;
                nCompared++;
                if ({mem_rdata_o, bus_cyc_o, timeout_err_o} !== {32'h0, 2'b01}) begin
                    nMismatched++; $display("[TB] FAIL timeout_ack: got rdata=%h cyc=%b err=%b expected 0 0 1", mem_rdata_o, bus_cyc_o, timeout_err_o);
                end
            end
        end
        nCompared++;
        if (ackAt !== TB_TIMEOUT + 2) begin
            nMismatched++; $display("[TB] FAIL timeout_latency: got ack at cycle %0d expected %0d", ackAt, TB_TIMEOUT + 2);
        end
        step(); step(); step();
        nCompared++;
        if (timeout_err_o !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL timeout_sticky: got %b expected 1", timeout_err_o);
        end
        do_reset();
        nCompared++;
        if (timeout_err_o !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL timeout_clear: got %b expected 0", timeout_err_o);
        end
    endtask
`endif

    // Random requesters and a random-latency bus slave checked against a transaction-level model.
    task automatic test_random();
        bit busy = 0, ownerI = 0, lastWasD = 0, ackD = 0, ackI = 0, nAckD, nAckI;
        bit dPend = 0, iPend = 0;
        logic [DATA_W-1:0] rdD = '0, rdI = '0;
        logic              expWe = 0;
        logic [ADDR_W-1:0] expAddr = '0;
        logic [DATA_W-1:0] expWdata = '0;
        logic [SEL_W-1:0]  expSel = '0;
        int waitLeft = 0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            nCompared++;
            if (bus_cyc_o !== busy) begin
                nMismatched++; $display("[TB] FAIL rand_cyc@%0d: got %b expected %b", c, bus_cyc_o, busy);
            end
            if (busy) begin
                nCompared++;
                if (bus_we_o !== expWe || bus_addr_o !== expAddr || bus_sel_o !== expSel || (!ownerI && bus_wdata_o !== expWdata)) begin
                    nMismatched++; $display("[TB] FAIL rand_bus@%0d: got we=%b addr=%h sel=%b wdata=%h expected %b %h %b %h", c, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, expWe, expAddr, expSel, expWdata);
                end
            end
            nCompared++;
            if ({mem_ack_o, if_ack_o, mem_rdata_o, if_rdata_o} !== {ackD, ackI, rdD, rdI}) begin
                nMismatched++; $display("[TB] FAIL rand_ack@%0d: got %b%b %h %h expected %b%b %h %h", c, mem_ack_o, if_ack_o, mem_rdata_o, if_rdata_o, ackD, ackI, rdD, rdI);
            end
            if (ackD) dPend = 0;
            if (ackI) iPend = 0;
            if (!dPend && $urandom_range(0, 2) == 0) begin
                dPend = 1;
                mem_we_i = 1'($urandom); mem_addr_i = $urandom; mem_data_i = $urandom; mem_sel_i = 4'($urandom);
            end
            if (!iPend && $urandom_range(0, 2) == 0) begin
                iPend = 1;
                if_addr_i = $urandom;
            end
            mem_ce_i = dPend; if_ce_i = iPend;
            settle();
            nCompared++;
            if ({stallreq_mem_o, stallreq_if_o} !== {dPend && !ackD, iPend && !ackI}) begin
                nMismatched++; $display("[TB] FAIL rand_stall@%0d: got %b%b expected %b%b", c, stallreq_mem_o, stallreq_if_o, dPend && !ackD, iPend && !ackI);
            end
            bus_rdata_i = $urandom;
            if (busy) begin
                bus_ack_i = (waitLeft == 0);
                waitLeft--;
            end else begin
                bus_ack_i = ($urandom_range(0, 3) == 0);
            end
            nAckD = 0; nAckI = 0;
            if (busy) begin
                if (bus_ack_i) begin
                    busy = 0;
                    if (ownerI) begin nAckI = 1; rdI = bus_rdata_i; end
                    else begin nAckD = 1; rdD = expWe ? '0 : bus_rdata_i; end
                end
            end else if (dPend && !ackD && !(lastWasD && iPend && !ackI)) begin
                busy = 1; ownerI = 0; lastWasD = 1; waitLeft = $urandom_range(0, 4);
                expWe = mem_we_i; expAddr = mem_addr_i; expWdata = mem_data_i; expSel = mem_sel_i;
            end else if (iPend && !ackI) begin
                busy = 1; ownerI = 1; lastWasD = 0; waitLeft = $urandom_range(0, 4);
                expWe = 0; expAddr = if_addr_i; expSel = '1;
            end
            ackD = nAckD; ackI = nAckI;
            step();
        end
        clear_inputs();
    endtask

    // Global guard so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_d_read();
        test_simultaneous();
        test_write();
        test_back_to_back();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
